// File: rtl/gesture_confirm_classifier_if.sv
// Window/result bundle between the motion front end, the gesture classifier
// and the output register. The master drives a completed window; the slave
// (the classifier) returns the classification and confirmation status.
interface gesture_confirm_classifier_if #(
    parameter int ACC_SUM_BITS   = 18,
    parameter int ACC_COUNT_BITS = 12,
    parameter int CONFIRM_COUNT  = 2
);
    localparam int STREAK_BITS = $clog2(CONFIRM_COUNT + 1);

    logic                             trigger;
    logic signed [ACC_SUM_BITS-1:0]   delta_x;
    logic signed [ACC_SUM_BITS-1:0]   delta_y;
    logic        [ACC_COUNT_BITS-1:0] total_events;

    logic [2:0]             gesture;
    logic                   gesture_valid;
    logic                   pass;
    logic [2:0]             candidate;
    logic [STREAK_BITS-1:0] streak;
    logic                   cooldown_active;

    modport master (
        output trigger, delta_x, delta_y, total_events,
        input  gesture, gesture_valid, pass, candidate, streak, cooldown_active
    );

    modport slave (
        input  trigger, delta_x, delta_y, total_events,
        output gesture, gesture_valid, pass, candidate, streak, cooldown_active
    );
endinterface

// File: rtl/gesture_confirm_classifier.sv
// Gesture classifier with multi-window confirmation and post-emit cooldown.
// Two-stage pipeline: stage 1 registers saturated magnitudes, signs and the
// pass gate; stage 2 classifies and runs the confirmation FSM.
// Optional macro GESTURE_DIAGONAL_EN enables 8-way (diagonal) classification;
// without it only codes 0-3 are produced.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no streak in progress, waiting for a passing window
// CONFIRM  | streak of agreeing passing windows is being counted
// COOLDOWN | gesture just emitted, windows ignored until counter expires
module gesture_confirm_classifier #(
    parameter int ACC_SUM_BITS     = 18,
    parameter int ACC_COUNT_BITS   = 12,
    parameter int MIN_EVENT_THRESH = 20,
    parameter int MOTION_THRESH    = 8,
    parameter int DIAG_SHIFT       = 1,
    parameter int CONFIRM_COUNT    = 2,
    parameter int COOLDOWN_CYCLES  = 1000
) (
    input logic                          clk,
    input logic                          rst,
    gesture_confirm_classifier_if.slave  bus
);
    localparam int MAG_BITS    = ACC_SUM_BITS - 1;
    localparam int WIDE_BITS   = MAG_BITS + DIAG_SHIFT;
    localparam int STREAK_BITS = $clog2(CONFIRM_COUNT + 1);
    localparam int CNT_BITS    = $clog2(COOLDOWN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CONFIRM, COOLDOWN} state_t;

    // |v| with the most negative value clamped to the largest positive magnitude
    function automatic logic [MAG_BITS-1:0] abs_sat(input logic [ACC_SUM_BITS-1:0] v);
        if (v == {1'b1, {MAG_BITS{1'b0}}}) begin
            return {MAG_BITS{1'b1}};
        end else if (v[ACC_SUM_BITS-1]) begin
            return MAG_BITS'(-v);
        end else begin
            return v[MAG_BITS-1:0];
        end
    endfunction

    logic [MAG_BITS-1:0] abs_x_d, abs_y_d, max_d;
    logic                gate_d, xpos_d, ypos_d;

    logic                s1_valid_q, s1_gate_q, s1_xpos_q, s1_ypos_q;
    logic [MAG_BITS-1:0] s1_abs_x_q, s1_abs_y_q;

    logic [WIDE_BITS-1:0] ax_w, ay_w;
    logic [2:0]           dir;

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [2:0]           cand_q, cand_d;
    logic [STREAK_BITS-1:0] streak_q, streak_d;
    logic [2:0]           gesture_q, gesture_d;
    logic                 gv_q, gv_d;
    logic                 pass_q, pass_d;
    logic                 cd_q, cd_d;

    // Stage-1 combinational: magnitudes, signs and the pass gate of the incoming window
    always_comb begin
        abs_x_d = abs_sat(bus.delta_x);
        abs_y_d = abs_sat(bus.delta_y);
        max_d   = (abs_x_d > abs_y_d) ? abs_x_d : abs_y_d;
        gate_d  = (bus.total_events >= ACC_COUNT_BITS'(MIN_EVENT_THRESH)) &&
                  (max_d >= MAG_BITS'(MOTION_THRESH));
        xpos_d  = !bus.delta_x[ACC_SUM_BITS-1] && (bus.delta_x != '0);
        ypos_d  = !bus.delta_y[ACC_SUM_BITS-1] && (bus.delta_y != '0);
    end

    // Stage-1 register: capture a window on every trigger
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_gate_q  <= 1'b0;
            s1_xpos_q  <= 1'b0;
            s1_ypos_q  <= 1'b0;
            s1_abs_x_q <= '0;
            s1_abs_y_q <= '0;
        end else begin
            s1_valid_q <= bus.trigger;
            if (bus.trigger) begin
                s1_gate_q  <= gate_d;
                s1_xpos_q  <= xpos_d;
                s1_ypos_q  <= ypos_d;
                s1_abs_x_q <= abs_x_d;
                s1_abs_y_q <= abs_y_d;
            end
        end
    end

    // Stage-2 direction decode; magnitudes widened so the diagonal shift cannot overflow
    always_comb begin
        ax_w = WIDE_BITS'(s1_abs_x_q);
        ay_w = WIDE_BITS'(s1_abs_y_q);
        if (ay_w > ax_w) begin
            dir = s1_ypos_q ? 3'd1 : 3'd0;
        end else begin
            dir = s1_xpos_q ? 3'd3 : 3'd2;
        end
`ifdef GESTURE_DIAGONAL_EN
        begin
            logic [WIDE_BITS-1:0] mx_w, mn_w;
            mx_w = (ay_w > ax_w) ? ay_w : ax_w;
            mn_w = (ay_w > ax_w) ? ax_w : ay_w;
            if ((mn_w << DIAG_SHIFT) >= mx_w) begin
                dir = {1'b1, s1_ypos_q, s1_xpos_q};
            end
        end
`endif
    end

    // Confirmation FSM next state and registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        streak_d  = streak_q;
        gesture_d = gesture_q;
        gv_d      = 1'b0;
        pass_d    = s1_valid_q && s1_gate_q;
        cd_d      = (state_q == COOLDOWN);
        unique case (state_q)
            IDLE: begin
                if (s1_valid_q && s1_gate_q) begin
                    cand_d = dir;
                    if (CONFIRM_COUNT == 1) begin
                        gesture_d = dir;
                        gv_d      = 1'b1;
                        streak_d  = '0;
                        cnt_d     = CNT_BITS'(COOLDOWN_CYCLES);
                        state_d   = COOLDOWN;
                    end else begin
                        streak_d = STREAK_BITS'(1);
                        state_d  = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (s1_valid_q) begin
                    if (!s1_gate_q) begin
                        streak_d = '0;
                        state_d  = IDLE;
                    end else if (dir != cand_q) begin
                        cand_d   = dir;
                        streak_d = STREAK_BITS'(1);
                    end else if (streak_q == STREAK_BITS'(CONFIRM_COUNT - 1)) begin
                        gesture_d = cand_q;
                        gv_d      = 1'b1;
                        streak_d  = '0;
                        cnt_d     = CNT_BITS'(COOLDOWN_CYCLES);
                        state_d   = COOLDOWN;
                    end else begin
                        streak_d = streak_q + STREAK_BITS'(1);
                    end
                end
            end
            COOLDOWN: begin
                // The window landing on the final count is still dropped.
                if (cnt_q == CNT_BITS'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            streak_q  <= '0;
            gesture_q <= '0;
            gv_q      <= 1'b0;
            pass_q    <= 1'b0;
            cd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            streak_q  <= streak_d;
            gesture_q <= gesture_d;
            gv_q      <= gv_d;
            pass_q    <= pass_d;
            cd_q      <= cd_d;
        end
    end

    assign bus.gesture         = gesture_q;
    assign bus.gesture_valid   = gv_q;
    assign bus.pass            = pass_q;
    assign bus.candidate       = cand_q;
    assign bus.streak          = streak_q;
    assign bus.cooldown_active = cd_q;
endmodule

// File: tb/tb_gesture_confirm_classifier.sv
// Self-checking bench for gesture_confirm_classifier: directed scenarios with
// literal expectations plus randomized windows, all compared every cycle
// against a window-level behavioural model.
module tb_gesture_confirm_classifier;
    localparam int W      = 18;
    localparam int CW     = 12;
    localparam int MIN_EV = 20;
    localparam int MOT    = 8;
    localparam int DS     = 1;
    localparam int CC     = 2;
    localparam int N_CD   = 1000;
    localparam int MAXMAG = (1 << (W - 1)) - 1;
`ifdef GESTURE_DIAGONAL_EN
    localparam bit DIAG_EN = 1'b1;
`else
    localparam bit DIAG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gesture_confirm_classifier_if #(.ACC_SUM_BITS(W), .ACC_COUNT_BITS(CW), .CONFIRM_COUNT(CC)) bus ();

    gesture_confirm_classifier #(
        .ACC_SUM_BITS(W), .ACC_COUNT_BITS(CW), .MIN_EVENT_THRESH(MIN_EV),
        .MOTION_THRESH(MOT), .DIAG_SHIFT(DS), .CONFIRM_COUNT(CC), .COOLDOWN_CYCLES(N_CD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Window-level reference: saturated magnitudes, gate and direction code.
    function automatic void classify(input int dx, input int dy, input int ev,
                                     output bit ok, output int dir);
        int ax, ay, mx, mn;
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        if (ax > MAXMAG) ax = MAXMAG;
        if (ay > MAXMAG) ay = MAXMAG;
        mx = (ax > ay) ? ax : ay;
        mn = (ax > ay) ? ay : ax;
        ok = (ev >= MIN_EV) && (mx >= MOT);
        if (DIAG_EN && (mn * (1 << DS) >= mx)) dir = 4 + ((dy > 0) ? 2 : 0) + ((dx > 0) ? 1 : 0);
        else if (ay > ax)                    dir = (dy > 0) ? 1 : 0;
        else                                 dir = (dx > 0) ? 3 : 2;
    endfunction

    // Model state: a window sampled at one edge is judged at the next edge.
    int  edge_no = 0;
    bit  pv;
    int  pdx, pdy, pev;
    int  m_gesture, m_cand, m_streak;
    bit  m_gv, m_pass, m_cd;
    bit  have_emit;
    int  emit_edge;
    bit  w_ok;
    int  w_dir;
    bit  in_cd;

    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            pv = 0; have_emit = 0;
            m_gesture = 0; m_cand = 0; m_streak = 0;
            m_gv = 0; m_pass = 0; m_cd = 0;
        end else begin
            m_gv   = 0;
            m_pass = 0;
            in_cd  = have_emit && (edge_no - emit_edge >= 1) && (edge_no - emit_edge <= N_CD);
            m_cd   = in_cd;
            if (pv) begin
                classify(pdx, pdy, pev, w_ok, w_dir);
                m_pass = w_ok;
                if (!in_cd) begin
                    if (!w_ok) begin
                        m_streak = 0;
                    end else begin
                        if (m_streak > 0 && w_dir == m_cand) m_streak++;
                        else begin m_cand = w_dir; m_streak = 1; end
                        if (m_streak == CC) begin
                            m_gesture = m_cand; m_gv = 1; m_streak = 0;
                            have_emit = 1; emit_edge = edge_no;
                        end
                    end
                end
            end
            pv  = bus.trigger;
            pdx = bus.delta_x;
            pdy = bus.delta_y;
            pev = int'(bus.total_events);
        end
        #1;
        check("gesture",         int'(bus.gesture),         m_gesture);
        check("gesture_valid",   int'(bus.gesture_valid),   int'(m_gv));
        check("pass",            int'(bus.pass),            int'(m_pass));
        check("candidate",       int'(bus.candidate),       m_cand);
        check("streak",          int'(bus.streak),          m_streak);
        check("cooldown_active", int'(bus.cooldown_active), int'(m_cd));
    end

    task automatic drive(input int dx, input int dy, input int ev);
        @(negedge clk);
        bus.trigger      = 1'b1;
        bus.delta_x      = W'(dx);
        bus.delta_y      = W'(dy);
        bus.total_events = CW'(ev);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.trigger = 1'b0;
        end
    endtask

    // One window; returns at the cycle its stage-2 outputs are visible.
    task automatic win(input int dx, input int dy, input int ev);
        drive(dx, dy, ev);
        gap(2);
    endtask

    task automatic wait_cd_end();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cooldown_active && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("cooldown_end_bound", int'(bus.cooldown_active), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, dx, dy, ev;
        bus.trigger = 1'b0; bus.delta_x = '0; bus.delta_y = '0; bus.total_events = '0;
        repeat (3) @(negedge clk);
        check("rst_gesture", int'(bus.gesture), 0);
        check("rst_candidate", int'(bus.candidate), 0);
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_gv", int'(bus.gesture_valid), 0);
            check("idle_pass", int'(bus.pass), 0);
            check("idle_streak", int'(bus.streak), 0);
            check("idle_cd", int'(bus.cooldown_active), 0);
        end

        // two back-to-back RIGHT windows, then exact cooldown length
        drive(40, 2, 30);
        drive(40, 2, 30);
        gap(1);
        check("right_pass1", int'(bus.pass), 1);
        @(negedge clk);
        check("right_gv", int'(bus.gesture_valid), 1);
        check("right_code", int'(bus.gesture), 3);
        check("cd_at_emit", int'(bus.cooldown_active), 0);
        cnt = 0;
        @(negedge clk);
        while (bus.cooldown_active && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("cooldown_len", cnt, 1000);

        // diagonal pair
        win(-30, -28, 30);
        win(-30, -28, 30);
        check("diag_gv", int'(bus.gesture_valid), 1);
        check("diag_code", int'(bus.gesture), DIAG_EN ? 4 : 2);
        wait_cd_end();

        // streak broken by a low-event window
        win(40, 2, 30);
        check("brk_streak1", int'(bus.streak), 1);
        win(40, 2, 5);
        check("brk_pass", int'(bus.pass), 0);
        check("brk_streak0", int'(bus.streak), 0);
        win(40, 2, 30);
        check("brk_gv_none", int'(bus.gesture_valid), 0);
        check("brk_streak_again", int'(bus.streak), 1);
        win(40, 2, 30);
        check("brk_gv", int'(bus.gesture_valid), 1);
        check("brk_code", int'(bus.gesture), 3);
        wait_cd_end();

        // direction change restarts the streak
        win(40, 2, 30);
        win(2, -40, 30);
        check("chg_streak", int'(bus.streak), 1);
        check("chg_cand", int'(bus.candidate), 0);
        win(2, -40, 30);
        check("chg_gv", int'(bus.gesture_valid), 1);
        check("chg_code", int'(bus.gesture), 0);

        // windows during cooldown pass but are ignored
        for (int i = 0; i < 3; i++) begin
            win(0, 50, 40);
            check("cd_pass", int'(bus.pass), 1);
            check("cd_no_gv", int'(bus.gesture_valid), 0);
            check("cd_active", int'(bus.cooldown_active), 1);
        end
        wait_cd_end();
        win(0, 50, 40);
        win(0, 50, 40);
        check("down_gv", int'(bus.gesture_valid), 1);
        check("down_code", int'(bus.gesture), 1);
        wait_cd_end();

        // most negative dx saturates and classifies LEFT
        win(-131072, 0, 30);
        check("sat_pass", int'(bus.pass), 1);
        check("sat_cand", int'(bus.candidate), 2);
        win(-131072, 0, 30);
        check("sat_code", int'(bus.gesture), 2);
        wait_cd_end();

        // inclusive thresholds
        win(8, 8, 20);
        check("thr_pass", int'(bus.pass), 1);
        check("thr_cand", int'(bus.candidate), DIAG_EN ? 7 : 3);
        win(7, 7, 50);
        check("thr_nopass", int'(bus.pass), 0);
        check("thr_streak", int'(bus.streak), 0);

        // randomized windows, back-to-back triggers and occasional reset
        dx = 0; dy = 0; ev = 0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2999) == 0) begin
                rst = 1'b1;
                bus.trigger = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 0) begin
                    dx = int'($urandom_range(0, 120)) - 60;
                    dy = int'($urandom_range(0, 120)) - 60;
                    case ($urandom_range(0, 15))
                        0: dx = -131072;
                        1: dy = 131071;
                        2: dy = -131072;
                        default: ;
                    endcase
                end
                ev = int'($urandom_range(0, 60));
                bus.trigger      = 1'b1;
                bus.delta_x      = W'(dx);
                bus.delta_y      = W'(dy);
                bus.total_events = CW'(ev);
            end else begin
                bus.trigger = 1'b0;
            end
        end
        gap(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gesture_confirm_classifier.md
Name: gesture_confirm_classifier

Overview:
Next-generation gesture classifier. It sits between MotionComputer and OutputRegister and consumes the per-window motion vector and event count. It classifies each window into 8 directions (4 with diagonals compiled out). A gesture is emitted only after CONFIRM_COUNT consecutive windows agree, and a cooldown then suppresses repeat detections. Absolute values are computed internally, and the datapath is a 2-stage pipeline that accepts a trigger every cycle.

Parameters:
ACC_SUM_BITS, 18, signed motion-vector width
ACC_COUNT_BITS, 12, unsigned event-count width
MIN_EVENT_THRESH, 20, minimum total_events for a window to pass
MOTION_THRESH, 8, minimum max(|dx|,|dy|) for a window to pass
DIAG_SHIFT, 1, diagonal when (min(|dx|,|dy|) << DIAG_SHIFT) >= max(|dx|,|dy|)
CONFIRM_COUNT, 2, consecutive agreeing passing windows needed to emit (>=1)
COOLDOWN_CYCLES, 1000, clk cycles detections are suppressed after an emit (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
trigger  input  1  window complete; sample delta_x, delta_y, total_events
delta_x  input  ACC_SUM_BITS  signed dx
delta_y  input  ACC_SUM_BITS  signed dy
total_events  input  ACC_COUNT_BITS  events in window
gesture  output  3  last confirmed gesture code
gesture_valid  output  1  one-cycle pulse on confirmed emit
pass  output  1  one-cycle pulse: the window passed both gates
candidate  output  3  direction of current streak
streak  output  $clog2(CONFIRM_COUNT+1)  current agreeing-window count
cooldown_active  output  1  high while suppression is in effect

Behaviour:
- Reset: gesture=0, gesture_valid=0, pass=0, candidate=0, streak=0, cooldown_active=0, FSM=IDLE, cooldown counter=0. A reset mid-streak or mid-cooldown discards all state.
- Codes: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 UP_LEFT, 5 UP_RIGHT, 6 DOWN_LEFT, 7 DOWN_RIGHT.
- Stage 1 (cycle T+1 after trigger at T):
  - Register |dx| and |dy|; the most negative input saturates to 2^(ACC_SUM_BITS-1)-1.
  - Register sign bits and gate_ok = (total_events >= MIN_EVENT_THRESH) && (max >= MOTION_THRESH).
- Stage 2 (cycle T+2): classify, run the FSM, and drive pass, gesture_valid and gesture. Latency from trigger to gesture_valid is 2 cycles.
- Classify:
  - Diagonal if min<<DIAG_SHIFT >= max, with the comparison widened by DIAG_SHIFT bits (no overflow).
  - Otherwise |dy| > |dx| gives vertical, and ties give horizontal.
  - Sign: delta > 0 gives DOWN/RIGHT; delta <= 0 gives UP/LEFT.
- FSM states IDLE, CONFIRM, COOLDOWN; evaluated only on a stage-2 valid window except the cooldown countdown.
  - IDLE: passing window sets candidate=dir and streak=1. If CONFIRM_COUNT==1, emit; otherwise go to CONFIRM. A failing window keeps IDLE.
  - CONFIRM, passing window with dir==candidate: streak++. If streak reaches CONFIRM_COUNT, emit.
  - CONFIRM, passing window with a different dir: candidate=dir, streak=1, stay in CONFIRM.
  - CONFIRM, failing window: streak=0, go to IDLE.
  - Emit: gesture=candidate, gesture_valid=1 for that cycle, streak=0, load counter=COOLDOWN_CYCLES, go to COOLDOWN.
  - COOLDOWN: cooldown_active=1 and the counter decrements each cycle. At the counter==1 cycle, go to IDLE, so cooldown_active is high for exactly COOLDOWN_CYCLES cycles starting the cycle after gesture_valid.
  - Windows evaluated in COOLDOWN still pulse pass but do not affect streak or candidate.
  - A window evaluated in the same cycle the FSM returns to IDLE is treated as in COOLDOWN (dropped).
- pass is pulsed for every passing window in every state; gesture holds between emits.
- Back-to-back triggers on consecutive cycles are each processed in order; nothing is lost.

Optional Feature:
Macro GESTURE_DIAGONAL_EN.
- Defined: 8-way classification as above.
- Undefined: diagonal test removed, output codes limited to 0-3, and DIAG_SHIFT unused; all other behaviour is identical.

Test Plan:
- Reset then idle: gesture_valid, pass, streak and cooldown_active stay 0 for 50 cycles.
- Two triggers with dx=+40, dy=+2, events=30: pass on both. gesture_valid occurs 2 cycles after the 2nd trigger with gesture=3 (RIGHT), then cooldown_active is high for exactly 1000 cycles.
- Triggers (dx=-30, dy=-28), (dx=-30, dy=-28) with diagonals on gives gesture=4 (UP_LEFT). With the macro undefined it gives gesture=2 (LEFT).
- Streak break: RIGHT window, then events=5 window (no pass, streak=0), then RIGHT, RIGHT gives a single emit only after the last one. Also RIGHT, UP, UP gives streak=1 at UP, then an emit of UP (0).
- Cooldown suppression: emit, then 3 DOWN windows (dy=+50, events=40) inside cooldown each pulse pass but give no gesture_valid. Two DOWN windows after cooldown gives gesture=1.
- Edge values:
  - dx = -2^17, dy = 0: |dx| saturates to 131071, classified LEFT.
  - dx=8, dy=8, events=20: passes (thresholds inclusive).
  - dx=7, dy=7: no pass.
